fp_div_operand_queue: RTL and testbench
=======================================

// Module: fp_div_operand_queue
// PURPOSE
// - Buffered issue stage directly upstream of the single-precision divider core.
// - Accepts operand pairs over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
// - Classifies each operand at enqueue; flushes denormals to signed zero.
// - Resolves IEEE special cases (NaN, inf, zero) so the core only ever sees normal/normal pairs;
//   special pairs leave with a precomputed result and out_bypass=1.
// PARAMETERS
// - DEPTH      4   FIFO entries; power of two, >=2
// - CNT_W      $clog2(DEPTH)+1   occupancy counter width (derived; do not override)
// PORTS
// - clk         in   1      single clock, all state on rising edge
// - rst         in   1      synchronous, active-high reset
// - in_valid    in   1      upstream offers an operand pair
// - in_ready    out  1      queue can accept; equals !full && !rst
// - in_opd1     in   32     dividend, IEEE-754 single
// - in_opd2     in   32     divisor, IEEE-754 single
// - out_valid   out  1      head entry presented to divider/result mux
// - out_ready   in   1      downstream consumes head
// - out_opd1    out  32     head dividend (denormal flushed)
// - out_opd2    out  32     head divisor (denormal flushed)
// - out_bypass  out  1      head is a special case; divider must not be used
// - out_special out  32     precomputed result, valid when out_bypass=1
// - out_dbz     out  1      divide-by-zero flag (finite nonzero / 0)
// - out_inv     out  1      invalid flag (0/0, inf/inf, any sNaN input)
// - count       out  CNT_W  current occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset: wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=0 during rst, 1 the cycle after.
// - Outputs other than out_valid are don't-care while out_valid=0; the bench must not check them.
// - Push: in_valid && in_ready. Pop: out_valid && out_ready.
// - Latency: an entry pushed in cycle N is at the head with out_valid=1 in cycle N+1 at the earliest.
//   There is no combinational in->out path.
// - Full (count==DEPTH):
//   - in_ready=0 even if a pop occurs in the same cycle (no pass-through on full).
// - Empty (count==0): out_valid=0; a push alone gives count=1 next cycle.
// - Simultaneous push+pop when 0<count<DEPTH: count unchanged, both pointers advance.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks full/empty, not pointer compare.
// - Head data is registered storage indexed by rd_ptr. It holds stable while out_valid && !out_ready.
// - rst mid-operation: all entries discarded next edge, out_valid=0; in-flight handshakes are void.
// Classification (per operand, at enqueue, stored with entry)
// - Classes: ZERO (exp=0, incl. denormal), NORM, INF (exp=FF, man=0), QNAN (exp=FF, man[22]=1),
//   SNAN (exp=FF, man!=0, man[22]=0).
// - Denormal flush: stored operand = {sign, 31'b0}.
// Special resolution (first match wins; s = sign1^sign2)
// - 1. either NaN                  -> QNAN_C (32'h7FC00000); out_inv=1 if either is SNAN
// - 2. ZERO/ZERO or INF/INF        -> QNAN_C, out_inv=1
// - 3. NORM/ZERO                   -> {s,8'hFF,23'b0}, out_dbz=1
// - 4. INF/ZERO or INF/NORM        -> {s,8'hFF,23'b0}
// - 5. ZERO/NORM, ZERO/INF, NORM/INF -> {s,31'b0}
// - 6. NORM/NORM                   -> out_bypass=0; out_special, out_dbz, out_inv = 0
// STRUCTURE
// - fp_div_pkg (shared with the divider and result stage) holds:
//   - typedef enum logic [2:0] fp_class_e {FC_ZERO, FC_NORM, FC_INF, FC_QNAN, FC_SNAN}
//   - localparam QNAN_C = 32'h7FC00000; localparam EXP_BIAS = 127
//   - typedef struct packed fp_div_entry_t {opd1, opd2, bypass, special, dbz, inv}
// - Sub-module fp_operand_classify: combinational, 32-bit in -> fp_class_e plus flushed value.
//   Instantiated twice on the write side.
// - Resolution logic runs before storage, so each FIFO entry is one fp_div_entry_t.
// TESTING
// - Fill/drain: out_ready=0, push 4 pairs -> count=4, in_ready=0; then out_ready=1 ->
//   pairs emerge in order over 4 cycles, count back to 0.
// - Streaming: in_valid=out_ready=1 with 10 NORM pairs (e.g. 3F800000/40000000) ->
//   after 1-cycle fill, one pop per cycle, count stays 1, out_bypass=0.
// - Specials: 40400000/00000000 -> bypass, special=7F800000, dbz=1;
//   00000000/80000000 -> 7FC00000, inv=1; 7F800000/C0000000 -> FF800000;
//   7F800001/3F800000 -> 7FC00000, inv=1.
// - Denormal flush: 80000001/3F800000 -> out_opd1=80000000, bypass=1, special=80000000.
// - Full-boundary: count=4 with push+pop in the same cycle -> pop accepted, push refused,
//   count=3 next cycle.
// - Reset mid-stream: rst for 1 cycle with count=3 -> next cycle out_valid=0, count=0;
//   the following push reappears at the head one cycle later.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divide path
// (operand queue, divider core and result stage).
package fp_div_pkg;

    typedef enum logic [2:0] {
        FC_ZERO,
        FC_NORM,
        FC_INF,
        FC_QNAN,
        FC_SNAN
    } fp_class_e;

    localparam logic [31:0] QNAN_C   = 32'h7FC00000;
    localparam int          EXP_BIAS = 127;
    // All-ones biased exponent marks inf/NaN.
    localparam logic [7:0]  EXP_MAX  = 8'(2 * EXP_BIAS + 1);

    typedef struct packed {
        logic [31:0] opd1;
        logic [31:0] opd2;
        logic        bypass;
        logic [31:0] special;
        logic        dbz;
        logic        inv;
    } fp_div_entry_t;

    function automatic logic [31:0] fp_signed_inf(input logic sign);
        return {sign, EXP_MAX, 23'b0};
    endfunction

    function automatic logic [31:0] fp_signed_zero(input logic sign);
        return {sign, 31'b0};
    endfunction

endpackage

// File: rtl/fp_operand_classify.sv
// Classifies one IEEE-754 single operand and flushes denormals to signed zero.
module fp_operand_classify
    import fp_div_pkg::*;
(
    input  logic [31:0] value,
    output fp_class_e   fclass,
    output logic [31:0] flushed
);

    logic [7:0]  exp_f;
    logic [22:0] man_f;

    assign exp_f = value[30:23];
    assign man_f = value[22:0];

    always_comb begin
        fclass  = FC_NORM;
        flushed = value;
        if (exp_f == 8'h00) begin
            // Denormals and true zeros both become a signed zero.
            fclass  = FC_ZERO;
            flushed = fp_signed_zero(value[31]);
        end else if (exp_f == EXP_MAX) begin
            if (man_f == 23'b0) begin
                fclass = FC_INF;
            end else if (man_f[22]) begin
                fclass = FC_QNAN;
            end else begin
                fclass = FC_SNAN;
            end
        end
    end

endmodule

// File: rtl/fp_div_operand_queue.sv
// Operand FIFO in front of the divider: classifies and resolves IEEE special
// cases on the write side so each stored entry is already final.
module fp_div_operand_queue
    import fp_div_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_opd1,
    input  logic [31:0]      in_opd2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_opd1,
    output logic [31:0]      out_opd2,
    output logic             out_bypass,
    output logic [31:0]      out_special,
    output logic             out_dbz,
    output logic             out_inv,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a beat transfers on a rising edge where valid && ready are both
    // high; valid never depends on ready, and the offered payload must stay
    // stable until that edge.

    fp_class_e        cls1, cls2;
    logic [31:0]      flush1, flush2;
    fp_div_entry_t    wr_entry;
    fp_div_entry_t    head;
    fp_div_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, push, pop;
    logic             sign_q;
    logic             nan1, nan2;

    fp_operand_classify u_cls1 (
        .value   (in_opd1),
        .fclass  (cls1),
        .flushed (flush1)
    );

    fp_operand_classify u_cls2 (
        .value   (in_opd2),
        .fclass  (cls2),
        .flushed (flush2)
    );

    assign sign_q = in_opd1[31] ^ in_opd2[31];
    assign nan1   = (cls1 == FC_QNAN) || (cls1 == FC_SNAN);
    assign nan2   = (cls2 == FC_QNAN) || (cls2 == FC_SNAN);

    // Special-case resolution, first matching rule wins.
    always_comb begin
        wr_entry         = '0;
        wr_entry.opd1    = flush1;
        wr_entry.opd2    = flush2;
        wr_entry.bypass  = 1'b1;
        if (nan1 || nan2) begin
            wr_entry.special = QNAN_C;
            wr_entry.inv     = (cls1 == FC_SNAN) || (cls2 == FC_SNAN);
        end else if ((cls1 == FC_ZERO && cls2 == FC_ZERO) ||
                     (cls1 == FC_INF  && cls2 == FC_INF)) begin
            wr_entry.special = QNAN_C;
            wr_entry.inv     = 1'b1;
        end else if (cls1 == FC_NORM && cls2 == FC_ZERO) begin
            wr_entry.special = fp_signed_inf(sign_q);
            wr_entry.dbz     = 1'b1;
        end else if (cls1 == FC_INF) begin
            wr_entry.special = fp_signed_inf(sign_q);
        end else if (cls1 == FC_NORM && cls2 == FC_NORM) begin
            wr_entry.bypass  = 1'b0;
        end else begin
            wr_entry.special = fp_signed_zero(sign_q);
        end
    end

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    // No pass-through when full: a same-cycle pop does not free a slot early.
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head        = mem[rd_ptr];
    assign out_opd1    = head.opd1;
    assign out_opd2    = head.opd2;
    assign out_bypass  = head.bypass;
    assign out_special = head.special;
    assign out_dbz     = head.dbz;
    assign out_inv     = head.inv;
    assign count       = count_q;

endmodule

// File: tb/tb_fp_div_operand_queue.sv
// Self-checking bench for fp_div_operand_queue: directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_fp_div_operand_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int W     = 99;

    localparam int C_ZERO = 0;
    localparam int C_NORM = 1;
    localparam int C_INF  = 2;
    localparam int C_QNAN = 3;
    localparam int C_SNAN = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_opd1;
    logic [31:0]      in_opd2;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_opd1;
    logic [31:0]      out_opd2;
    logic             out_bypass;
    logic [31:0]      out_special;
    logic             out_dbz;
    logic             out_inv;
    logic [CNT_W-1:0] count;

    logic [W-1:0] exp_q[$];
    int           tests_run;
    int           tests_failed;
    logic         last_push;
    logic         last_pop;

    fp_div_operand_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opd1     (in_opd1),
        .in_opd2     (in_opd2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opd1    (out_opd1),
        .out_opd2    (out_opd2),
        .out_bypass  (out_bypass),
        .out_special (out_special),
        .out_dbz     (out_dbz),
        .out_inv     (out_inv),
        .count       (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_cls(input logic [31:0] x);
        if (x[30:23] == 8'h00) return C_ZERO;
        if (x[30:23] != 8'hFF) return C_NORM;
        if (x[22:0] == 23'b0) return C_INF;
        return x[22] ? C_QNAN : C_SNAN;
    endfunction

    function automatic logic [W-1:0] ref_entry(input logic [31:0] a, input logic [31:0] b);
        int          ca, cb;
        logic        s, byp, dbz, inv;
        logic [31:0] fa, fb, sp;
        ca  = ref_cls(a);
        cb  = ref_cls(b);
        s   = a[31] ^ b[31];
        fa  = (ca == C_ZERO) ? {a[31], 31'b0} : a;
        fb  = (cb == C_ZERO) ? {b[31], 31'b0} : b;
        byp = 1'b1;
        dbz = 1'b0;
        inv = 1'b0;
        sp  = 32'h0;
        if (ca >= C_QNAN || cb >= C_QNAN) begin
            sp  = 32'h7FC00000;
            inv = (ca == C_SNAN) || (cb == C_SNAN);
        end else if (ca == cb && ca != C_NORM) begin
            sp  = 32'h7FC00000;
            inv = 1'b1;
        end else if (ca == C_NORM && cb == C_ZERO) begin
            sp  = {s, 31'h7F800000};
            dbz = 1'b1;
        end else if (ca == C_INF) begin
            sp  = {s, 31'h7F800000};
        end else if (ca == C_NORM && cb == C_NORM) begin
            byp = 1'b0;
        end else begin
            sp  = {s, 31'b0};
        end
        return {fa, fb, byp, sp, dbz, inv};
    endfunction

    function automatic logic [31:0] gen_opd();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 5))
            0:       return {s, 31'b0};
            1:       return {s, 8'h00, (m == 0) ? 23'h1 : m};
            2:       return {s, 8'($urandom_range(1, 254)), m};
            3:       return {s, 8'hFF, 23'b0};
            4:       return {s, 8'hFF, 1'b1, m[21:0]};
            default: return {s, 8'hFF, 1'b0, (m[21:0] == 0) ? 22'h1 : m[21:0]};
        endcase
    endfunction

    function automatic logic [31:0] gen_norm();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    // ---------------- driver + scoreboard ----------------
    // Drives one cycle (rst low), checks occupancy/flags against the model,
    // scores the popped head, and queues the pushed pair's expected entry.
    task automatic sb_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic rdy);
        logic [W-1:0] got, want;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = v;
        in_opd1   = a;
        in_opd2   = b;
        out_ready = rdy;
        #1;
        tests_run++;
        if (count !== CNT_W'(exp_q.size())) begin
            tests_failed++;
            $display("FAIL count: got %0d want %0d", count, exp_q.size());
        end
        tests_run++;
        if (out_valid !== (exp_q.size() != 0)) begin
            tests_failed++;
            $display("FAIL out_valid: got %b want %b", out_valid, exp_q.size() != 0);
        end
        tests_run++;
        if (in_ready !== (exp_q.size() < DEPTH)) begin
            tests_failed++;
            $display("FAIL in_ready: got %b want %b", in_ready, exp_q.size() < DEPTH);
        end
        last_pop  = out_valid && out_ready;
        last_push = in_valid && in_ready;
        if (last_pop) begin
            got = {out_opd1, out_opd2, out_bypass, out_special, out_dbz, out_inv};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL head_unexpected: got %h want no entry", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    tests_failed++;
                    $display("FAIL head_data: got %h want %h", got, want);
                end
            end
        end
        if (last_push) exp_q.push_back(ref_entry(a, b));
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) begin
            sb_cycle(1'b0, 32'h0, 32'h0, 1'b1);
        end
        sb_cycle(1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (count !== '0) begin
            tests_failed++;
            $display("FAIL drain_empty: got count %0d want 0", count);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_opd1 = '0;
        in_opd2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0 || count !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got valid %b count %0d want 0 0", out_valid, count);
        end
        exp_q.delete();
        sb_cycle(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) sb_cycle(1'b1, gen_norm(), gen_norm(), 1'b0);
        sb_cycle(1'b1, gen_norm(), gen_norm(), 1'b0);
        tests_run++;
        if (count !== CNT_W'(DEPTH) || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: got count %0d ready %b want %0d 0", count, in_ready, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) sb_cycle(1'b0, 32'h0, 32'h0, 1'b1);
        sb_cycle(1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (count !== '0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_done: got count %0d valid %b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 10; i++) begin
            sb_cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b1);
            if (i > 0) begin
                tests_run++;
                if (count !== CNT_W'(1) || out_bypass !== 1'b0 || !last_pop) begin
                    tests_failed++;
                    $display("FAIL stream_%0d: got count %0d bypass %b pop %b want 1 0 1",
                             i, count, out_bypass, last_pop);
                end
            end
        end
        drain();
    endtask

    task automatic test_specials();
        logic [31:0] a_t [5] = '{32'h40400000, 32'h00000000, 32'h7F800000, 32'h7F800001, 32'h80000001};
        logic [31:0] b_t [5] = '{32'h00000000, 32'h80000000, 32'hC0000000, 32'h3F800000, 32'h3F800000};
        logic [31:0] s_t [5] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000};
        logic        d_t [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        v_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            sb_cycle(1'b1, a_t[i], b_t[i], 1'b0);
            sb_cycle(1'b0, 32'h0, 32'h0, 1'b1);
            tests_run++;
            if (out_bypass !== 1'b1 || out_special !== s_t[i] || out_dbz !== d_t[i] ||
                out_inv !== v_t[i]) begin
                tests_failed++;
                $display("FAIL special_%0d: got byp %b sp %h dbz %b inv %b want 1 %h %b %b",
                         i, out_bypass, out_special, out_dbz, out_inv, s_t[i], d_t[i], v_t[i]);
            end
            if (i == 4) begin
                tests_run++;
                if (out_opd1 !== 32'h80000000) begin
                    tests_failed++;
                    $display("FAIL denorm_flush: got %h want 80000000", out_opd1);
                end
            end
        end
        drain();
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < DEPTH; i++) sb_cycle(1'b1, gen_norm(), gen_norm(), 1'b0);
        sb_cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b1);
        tests_run++;
        if (in_ready !== 1'b0 || !last_pop || last_push) begin
            tests_failed++;
            $display("FAIL full_pushpop: got ready %b pop %b push %b want 0 1 0",
                     in_ready, last_pop, last_push);
        end
        sb_cycle(1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (count !== CNT_W'(DEPTH - 1)) begin
            tests_failed++;
            $display("FAIL full_after: got count %0d want %0d", count, DEPTH - 1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        for (int i = 0; i < 3; i++) sb_cycle(1'b1, gen_norm(), gen_norm(), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_ready: got %b want 0", in_ready);
        end
        exp_q.delete();
        a = gen_norm();
        b = gen_opd();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_opd1 = a;
        in_opd2 = b;
        out_ready = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_state: got valid %b count %0d ready %b want 0 0 1",
                     out_valid, count, in_ready);
        end
        exp_q.push_back(ref_entry(a, b));
        sb_cycle(1'b0, 32'h0, 32'h0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_head: got valid %b want 1", out_valid);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            sb_cycle(1'($urandom_range(0, 3) != 0), gen_opd(), gen_opd(),
                     1'($urandom_range(0, 2) != 0));
        end
        drain();
    endtask

    // ---------------- sequencing + report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        last_push    = 1'b0;
        last_pop     = 1'b0;
        test_reset();
        test_fill_drain();
        test_streaming();
        test_specials();
        test_full_boundary();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
